// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/sub sequencer.
package serial_add_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bus of the serial adder.
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = NIBBLE_W * NIBBLES;

    logic         start;
    logic         ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    modport master (
        output start, op_sub, a, b, ci,
        input  ready, done, s, co, ovf
    );

    modport slave (
        input  start, op_sub, a, b, ci,
        output ready, done, s, co, ovf
    );

endinterface

// File: rtl/fa4_mbit.sv
// Existing combinational 4-bit adder used as the shared datapath slice.
module fa4_mbit
    import serial_add_ctrl_pkg::*;
(
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci
);
    localparam int unsigned SW = NIBBLE_W + 1;

    assign {co, s} = SW'(a) + SW'(b) + SW'(ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer running one 4-bit adder over NIBBLES cycles, LSB nibble first.
// Subtraction is a + ~b + 1, so the operand registers hold b already inverted.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_r, a_n, b_r, b_n, s_r, s_n;
    logic carry, carry_n;
    logic co_r, co_n, ovf_r, ovf_n;
    logic done_r, done_n, ready_r, ready_n;

    logic [NIBBLE_W-1:0] add_s;
    logic                add_co;

    fa4_mbit u_fa4 (
        .s  (add_s),
        .co (add_co),
        .a  (a_r[idx]),
        .b  (b_r[idx]),
        .ci (carry)
    );

    // Next-state and next-register logic
    always_comb begin
        state_n = state;
        idx_n   = idx;
        a_n     = a_r;
        b_n     = b_r;
        carry_n = carry;
        s_n     = s_r;
        co_n    = co_r;
        ovf_n   = ovf_r;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a;
                    b_n     = bus.op_sub ? ~bus.b : bus.b;
                    carry_n = bus.op_sub ? 1'b1 : bus.ci;
                    idx_n   = '0;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                s_n[idx] = add_s;
                carry_n  = add_co;
                if (idx == IDX_LAST) begin
                    co_n    = add_co;
                    ovf_n   = (a_r[NIBBLES-1][NIBBLE_W-1] == b_r[NIBBLES-1][NIBBLE_W-1]) &&
                              (add_s[NIBBLE_W-1] != a_r[NIBBLES-1][NIBBLE_W-1]);
                    state_n = ST_DONE;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
            end
        endcase

        done_n  = (state_n == ST_DONE);
        ready_n = (state_n == ST_IDLE);
    end

    // State and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry   <= 1'b0;
            s_r     <= '0;
            co_r    <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            a_r     <= a_n;
            b_r     <= b_n;
            carry   <= carry_n;
            s_r     <= s_n;
            co_r    <= co_n;
            ovf_r   <= ovf_n;
            done_r  <= done_n;
            ready_r <= ready_n;
        end
    end

    assign bus.s     = s_r;
    assign bus.co    = co_r;
    assign bus.ovf   = ovf_r;
    assign bus.done  = done_r;
    assign bus.ready = ready_r;

endmodule
